dsp_power_load_ctrl: RTL and testbench

- Parametrised successor to the fixed DSP column array used for VCK190 power measurement.
- Sits between the host register bank and the DSP columns. Drives per-column clock enable and stimulus data, and folds the column outputs into one keep-alive output.
- Adds features the fixed array lacks: exact per-cycle toggle-rate control, column masking, soft-start/soft-stop ramping to limit di/dt, and a burst (duty-cycled) load mode.

---
 rtl/dsp_power_load_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_dsp_power_load_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_power_load_ctrl.sv
// Power-load controller for a bank of DSP columns: ramps column clock
// enables up and down in timed steps, drives toggling stimulus data at a
// programmable rate, optionally duty-cycles the load in bursts, and folds
// the column outputs into a single keep-alive bit.
module dsp_power_load_ctrl #(
    parameter int unsigned NUM_DSP_COLUMN   = 5,
    parameter int unsigned NUM_DSP_BLOCK    = 110,
    parameter int unsigned DATA_W           = 27,
    parameter int unsigned RAMP_STEP_CYCLES = 256,
    parameter int unsigned BURST_W          = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enable,
    input  logic [6:0]                           TOGGLE_RATE,
    input  logic [NUM_DSP_COLUMN-1:0]            col_mask,
    input  logic                                 burst_mode,
    input  logic [BURST_W-1:0]                   burst_on,
    input  logic [BURST_W-1:0]                   burst_off,
    input  logic [NUM_DSP_COLUMN-1:0]            dsp_o,
    output logic [NUM_DSP_COLUMN-1:0]            col_ce,
    output logic [NUM_DSP_COLUMN*DATA_W-1:0]     col_data,
    output logic [1:0]                           state_o,
    output logic [$clog2(NUM_DSP_COLUMN+1)-1:0]  active_cols,
    output logic                                 dsp_top_o
);

    localparam int unsigned ACW    = $clog2(NUM_DSP_COLUMN + 1);
    localparam int unsigned STEP_W = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_STEP_CYCLES - 1);

    if (RAMP_STEP_CYCLES < 1 || NUM_DSP_BLOCK < 1) begin : g_param_check
        $error("RAMP_STEP_CYCLES and NUM_DSP_BLOCK must both be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    state_t                            state_q, state_d;
    logic [NUM_DSP_COLUMN-1:0]         mask_q, mask_d;
    logic [NUM_DSP_COLUMN-1:0]         en_q, en_d;
    logic [NUM_DSP_COLUMN-1:0]         ce_q, ce_d;
    logic [STEP_W-1:0]                 step_q, step_d;
    logic                              step_wrap;
    logic                              gate_q, gate_d;
    logic [BURST_W-1:0]                bcnt_q, bcnt_d;
    logic [6:0]                        acc_q, acc_d;
    logic                              tog_q, tog_d;
    logic [6:0]                        rate_c;
    logic [7:0]                        sum;
    logic [7:0]                        sum_wrapped;
    logic [NUM_DSP_COLUMN*DATA_W-1:0]  data_q, data_d;
    logic [ACW-1:0]                    act_q;
    logic                              top_q;

    // Lowest set bit of v isolated (zero if v is zero).
    function automatic logic [NUM_DSP_COLUMN-1:0] lowest_bit(input logic [NUM_DSP_COLUMN-1:0] v);
        logic [NUM_DSP_COLUMN-1:0] r;
        logic                      found;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_DSP_COLUMN; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // v with its highest set bit cleared.
    function automatic logic [NUM_DSP_COLUMN-1:0] clear_highest(input logic [NUM_DSP_COLUMN-1:0] v);
        logic [NUM_DSP_COLUMN-1:0] r;
        logic                      found;
        r     = v;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_DSP_COLUMN; k++) begin
            if (v[NUM_DSP_COLUMN-1-k] && !found) begin
                r[NUM_DSP_COLUMN-1-k] = 1'b0;
                found                 = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [ACW-1:0] popcount(input logic [NUM_DSP_COLUMN-1:0] v);
        logic [ACW-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < NUM_DSP_COLUMN; i++) begin
            n = n + ACW'(v[i]);
        end
        return n;
    endfunction

    // Alternating 1010..0 base pattern rotated left by col, optionally inverted.
    function automatic logic [DATA_W-1:0] col_pattern(input int unsigned col, input logic inv);
        logic [DATA_W-1:0] pat;
        pat = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            pat[(i + col) % DATA_W] = i[0];
        end
        return inv ? ~pat : pat;
    endfunction

    assign step_wrap = (step_q == STEP_LAST);

    // Ramp sequencer: state, latched mask, enabled-column set and step timer.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        en_d    = en_q;
        step_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    mask_d  = col_mask;
                    en_d    = lowest_bit(col_mask);
                    state_d = (col_mask == '0) ? ST_RUN : ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                if (!enable) begin
                    en_d    = clear_highest(en_q);
                    state_d = (en_d == '0) ? ST_IDLE : ST_RAMP_DOWN;
                end else begin
                    step_d = step_wrap ? '0 : step_q + STEP_W'(1);
                    if (step_wrap) begin
                        en_d = en_q | lowest_bit(mask_q & ~en_q);
                    end
                    if (en_d == mask_q) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    en_d    = clear_highest(en_q);
                    state_d = (en_d == '0) ? ST_IDLE : ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (enable) begin
                    state_d = ST_RAMP_UP;
                end else begin
                    step_d = step_wrap ? '0 : step_q + STEP_W'(1);
                    if (step_wrap) begin
                        en_d = clear_highest(en_q);
                    end
                    if (en_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                en_d    = '0;
            end
        endcase
    end

    // Burst gate: ON/OFF phase counters that only run while in RUN, plus the
    // gated clock enable. Gate is computed for the next cycle so that it lines
    // up with the registered enable set.
    always_comb begin
        gate_d = 1'b1;
        bcnt_d = '0;
        if (state_d == ST_RUN) begin
            if (state_q != ST_RUN) begin
                gate_d = (burst_on != '0);
            end else if (burst_on == '0) begin
                gate_d = 1'b0;
            end else if (burst_off == '0) begin
                gate_d = 1'b1;
            end else if (gate_q) begin
                if (bcnt_q >= burst_on - BURST_W'(1)) begin
                    gate_d = 1'b0;
                end else begin
                    gate_d = 1'b1;
                    bcnt_d = bcnt_q + BURST_W'(1);
                end
            end else begin
                if (bcnt_q >= burst_off - BURST_W'(1)) begin
                    gate_d = 1'b1;
                end else begin
                    gate_d = 1'b0;
                    bcnt_d = bcnt_q + BURST_W'(1);
                end
            end
        end
        ce_d = (state_d == ST_RUN && burst_mode) ? (en_d & {NUM_DSP_COLUMN{gate_d}}) : en_d;
    end

    // Toggle-rate accumulator and per-column stimulus data; idle columns hold.
    always_comb begin
        rate_c      = (TOGGLE_RATE > 7'd100) ? 7'd100 : TOGGLE_RATE;
        sum         = {1'b0, acc_q} + {1'b0, rate_c};
        sum_wrapped = sum - 8'd100;
        acc_d       = acc_q;
        tog_d       = tog_q;
        data_d      = data_q;
        if (ce_q != '0) begin
            if (sum >= 8'd100) begin
                acc_d = sum_wrapped[6:0];
                tog_d = ~tog_q;
            end else begin
                acc_d = sum[6:0];
            end
        end
        for (int unsigned c = 0; c < NUM_DSP_COLUMN; c++) begin
            if (ce_q[c]) begin
                data_d[c*DATA_W +: DATA_W] = col_pattern(c, tog_d);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            en_q    <= '0;
            ce_q    <= '0;
            step_q  <= '0;
            gate_q  <= 1'b1;
            bcnt_q  <= '0;
            acc_q   <= '0;
            tog_q   <= 1'b0;
            act_q   <= '0;
            top_q   <= 1'b0;
            for (int unsigned c = 0; c < NUM_DSP_COLUMN; c++) begin
                data_q[c*DATA_W +: DATA_W] <= col_pattern(c, 1'b0);
            end
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            en_q    <= en_d;
            ce_q    <= ce_d;
            step_q  <= step_d;
            gate_q  <= gate_d;
            bcnt_q  <= bcnt_d;
            acc_q   <= acc_d;
            tog_q   <= tog_d;
            data_q  <= data_d;
            act_q   <= popcount(en_d);
            top_q   <= ^dsp_o;
        end
    end

    assign col_ce      = ce_q;
    assign col_data    = data_q;
    assign state_o     = state_q;
    assign active_cols = act_q;
    assign dsp_top_o   = top_q;

endmodule

// File: tb/tb_dsp_power_load_ctrl.sv
// Scoreboard bench for dsp_power_load_ctrl: expectations are queued with the
// cycle they are due and checked on the falling edge of that cycle.
module tb_dsp_power_load_ctrl;

    localparam int NC  = 5;
    localparam int DW  = 27;
    localparam int BW  = 16;
    localparam int ACW = $clog2(NC + 1);

    localparam int F_CE   = 0;
    localparam int F_ST   = 1;
    localparam int F_AC   = 2;
    localparam int F_TOP  = 3;
    localparam int F_DATA = 4;

    typedef logic [NC*DW-1:0] vec_t;
    typedef struct {
        int    cyc;
        int    fld;
        vec_t  val;
        string tag;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic [6:0]      rate = 7'd0;
    logic [NC-1:0]   col_mask = '0;
    logic            burst_mode = 1'b0;
    logic [BW-1:0]   burst_on = 16'd3;
    logic [BW-1:0]   burst_off = 16'd2;
    logic [NC-1:0]   dsp_o = '0;
    logic [NC-1:0]   col_ce;
    vec_t            col_data;
    logic [1:0]      state_o;
    logic [ACW-1:0]  active_cols;
    logic            dsp_top_o;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t RST_V;
    vec_t INV_V;
    vec_t C0_INV_V;
    int   f;

    dsp_power_load_ctrl #(
        .NUM_DSP_COLUMN  (NC),
        .NUM_DSP_BLOCK   (110),
        .DATA_W          (DW),
        .RAMP_STEP_CYCLES(4),
        .BURST_W         (BW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .TOGGLE_RATE(rate),
        .col_mask   (col_mask),
        .burst_mode (burst_mode),
        .burst_on   (burst_on),
        .burst_off  (burst_off),
        .dsp_o      (dsp_o),
        .col_ce     (col_ce),
        .col_data   (col_data),
        .state_o    (state_o),
        .active_cols(active_cols),
        .dsp_top_o  (dsp_top_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input vec_t got, input vec_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t field(input int fld);
        case (fld)
            F_CE:    return vec_t'(col_ce);
            F_ST:    return vec_t'(state_o);
            F_AC:    return vec_t'(active_cols);
            F_TOP:   return vec_t'(dsp_top_o);
            default: return col_data;
        endcase
    endfunction

    task automatic expect_at(input int dly, input int fld, input vec_t v, input string name);
        exp_t e;
        e.cyc = cyc + dly;
        e.fld = fld;
        e.val = v;
        e.tag = $sformatf("%s@%0d", name, cyc + dly);
        sb.push_back(e);
    endtask

    task automatic ex_ce(input int d, input logic [NC-1:0] v);
        expect_at(d, F_CE, vec_t'(v), "col_ce");
    endtask
    task automatic ex_st(input int d, input logic [1:0] v);
        expect_at(d, F_ST, vec_t'(v), "state");
    endtask
    task automatic ex_ac(input int d, input int v);
        expect_at(d, F_AC, vec_t'(v), "active_cols");
    endtask
    task automatic ex_top(input int d, input logic v);
        expect_at(d, F_TOP, vec_t'(v), "dsp_top");
    endtask
    task automatic ex_data(input int d, input vec_t v);
        expect_at(d, F_DATA, v, "col_data");
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts changes of column 0 data over n cycles.
    task automatic count_flips(input int n, output int flips);
        logic [DW-1:0] prev;
        flips = 0;
        prev  = col_data[DW-1:0];
        repeat (n) begin
            @(negedge clk);
            if (col_data[DW-1:0] !== prev) flips++;
            prev = col_data[DW-1:0];
        end
    endtask

    // Scoreboard drain: compare every entry due this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check_eq(sb[i].tag, field(sb[i].fld), sb[i].val);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                check_eq({sb[i].tag, "_late"}, vec_t'(cyc), vec_t'(sb[i].cyc));
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: cycle %0d reached without finishing", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < NC; c++) begin
            for (int j = 0; j < DW; j++) begin
                RST_V[c*DW + j] = (((j - c + DW) % DW) % 2) == 1;
            end
        end
        INV_V              = ~RST_V;
        C0_INV_V           = RST_V;
        C0_INV_V[DW-1:0]   = ~RST_V[DW-1:0];

        // Reset values
        tick(2);
        ex_ce(1, 5'b00000); ex_st(1, 2'd0); ex_ac(1, 0); ex_top(1, 1'b0); ex_data(1, RST_V);
        tick(2);
        rst = 1'b0;

        // Ramp up with sparse mask
        col_mask = 5'b10110;
        enable   = 1'b1;
        ex_ce(1, 5'b00010); ex_st(1, 2'd1); ex_ac(1, 1);
        ex_ce(4, 5'b00010); ex_ce(5, 5'b00110); ex_ac(5, 2);
        ex_ce(8, 5'b00110); ex_st(8, 2'd1);
        ex_ce(9, 5'b10110); ex_st(9, 2'd2); ex_ac(9, 3); ex_data(9, RST_V);
        tick(10);

        // Ramp down to idle
        enable = 1'b0;
        ex_ce(1, 5'b00110); ex_st(1, 2'd3);
        ex_ce(4, 5'b00110); ex_ce(5, 5'b00010);
        ex_ce(8, 5'b00010); ex_ce(9, 5'b00000); ex_st(9, 2'd0); ex_ac(9, 0);
        tick(12);

        // Toggle rate
        col_mask = 5'b11111;
        rate     = 7'd25;
        enable   = 1'b1;
        ex_ce(1, 5'b00001); ex_data(5, C0_INV_V);
        ex_st(16, 2'd1); ex_ce(17, 5'b11111); ex_st(17, 2'd2); ex_ac(17, 5);
        tick(17);
        count_flips(400, f);
        check_eq("flips_rate25", vec_t'(f), vec_t'(100));
        rate = 7'd0;
        ex_data(1, RST_V);
        count_flips(50, f);
        check_eq("flips_rate0", vec_t'(f), vec_t'(0));
        rate = 7'd100;
        ex_data(1, INV_V);
        count_flips(50, f);
        check_eq("flips_rate100", vec_t'(f), vec_t'(50));
        rate = 7'd120;
        ex_data(1, INV_V);
        count_flips(50, f);
        check_eq("flips_rate120", vec_t'(f), vec_t'(50));
        rate   = 7'd0;
        enable = 1'b0;
        ex_data(1, RST_V);
        ex_ce(1, 5'b01111); ex_ce(5, 5'b00111); ex_ce(9, 5'b00011); ex_ce(13, 5'b00001);
        ex_st(16, 2'd3); ex_ce(17, 5'b00000); ex_st(17, 2'd0);
        tick(18);

        // Burst gating
        col_mask   = 5'b01011;
        rate       = 7'd50;
        burst_mode = 1'b1;
        burst_on   = 16'd3;
        burst_off  = 16'd2;
        enable     = 1'b1;
        ex_ce(1, 5'b00001); ex_ce(5, 5'b00011); ex_st(9, 2'd2);
        for (int k = 0; k < 20; k++) ex_ce(9 + k, ((k % 5) < 3) ? 5'b01011 : 5'b00000);
        tick(9);
        count_flips(20, f);
        check_eq("flips_burst", vec_t'(f), vec_t'(6));
        burst_on = 16'd0;
        for (int k = 1; k <= 6; k++) ex_ce(k, 5'b00000);
        ex_st(3, 2'd2);
        tick(6);
        burst_mode = 1'b0;
        burst_on   = 16'd3;
        ex_ce(1, 5'b01011);
        tick(2);
        rate   = 7'd0;
        enable = 1'b0;
        ex_ce(1, 5'b00011); ex_ce(5, 5'b00001); ex_ce(9, 5'b00000); ex_st(9, 2'd0);
        tick(10);

        // Mid-ramp reversal and resume
        col_mask = 5'b11111;
        enable   = 1'b1;
        ex_ce(1, 5'b00001); ex_ce(5, 5'b00011);
        tick(5);
        enable = 1'b0;
        ex_ce(1, 5'b00001); ex_st(1, 2'd3);
        tick(1);
        enable = 1'b1;
        ex_st(1, 2'd1); ex_ce(1, 5'b00001); ex_ce(4, 5'b00001); ex_ce(5, 5'b00011);
        ex_ce(9, 5'b00111); ex_ce(13, 5'b01111);
        ex_ce(17, 5'b11111); ex_st(17, 2'd2); ex_ac(17, 5);
        tick(18);
        col_mask = 5'b00001;
        for (int k = 1; k <= 5; k++) ex_ce(k, 5'b11111);
        ex_ac(5, 5); ex_st(5, 2'd2);
        tick(6);
        enable = 1'b0;
        ex_st(17, 2'd0); ex_ce(17, 5'b00000);
        tick(18);

        // Empty mask
        col_mask = 5'b00000;
        enable   = 1'b1;
        ex_st(1, 2'd2); ex_ce(1, 5'b00000); ex_ac(1, 0); ex_st(2, 2'd2);
        tick(3);
        enable = 1'b0;
        ex_st(1, 2'd0);
        tick(2);

        // Reset mid-ramp, then output fold
        col_mask = 5'b11111;
        rate     = 7'd100;
        dsp_o    = 5'b11111;
        enable   = 1'b1;
        ex_top(1, 1'b1); ex_ce(5, 5'b00011);
        tick(6);
        rst    = 1'b1;
        enable = 1'b0;
        ex_ce(1, 5'b00000); ex_st(1, 2'd0); ex_ac(1, 0); ex_top(1, 1'b0); ex_data(1, RST_V);
        tick(1);
        rst   = 1'b0;
        dsp_o = 5'b01101;
        ex_top(1, 1'b1); ex_st(1, 2'd0);
        tick(1);
        dsp_o = 5'b00000;
        ex_top(1, 1'b0);
        tick(1);
        dsp_o = 5'b00011;
        ex_top(1, 1'b0);
        tick(3);

        check_eq("sb_pending", vec_t'(sb.size()), vec_t'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
